// File: rtl/prog_rom_pkg.sv
// Shared constants and loader state encodings for the program ROM download path.
// The graphics loader reuses the ROM index constants and the image decoder.
package prog_rom_pkg;

   localparam int unsigned ROM_BYTES   = 8192;
   localparam int unsigned ROM_COUNT   = 5;
   localparam int unsigned IMAGE_BYTES = ROM_BYTES * ROM_COUNT;

   localparam int unsigned IDX_1F = 0;
   localparam int unsigned IDX_1H = 1;
   localparam int unsigned IDX_1K = 2;
   localparam int unsigned IDX_1L = 3;
   localparam int unsigned IDX_1N = 4;

   typedef logic [2:0] loader_state_t;

   localparam loader_state_t ST_IDLE    = 3'd0;
   localparam loader_state_t ST_LOAD    = 3'd1;
   localparam loader_state_t ST_WRITE   = 3'd2;
   localparam loader_state_t ST_SETTLE  = 3'd3;
   localparam loader_state_t ST_RELEASE = 3'd4;
   localparam loader_state_t ST_DONE    = 3'd5;
   localparam loader_state_t ST_ERROR   = 3'd6;

endpackage

// File: rtl/rom_image_decode.sv
// Maps a download byte offset onto {in-range, one-hot ROM select, address within ROM}.
module rom_image_decode
   import prog_rom_pkg::*;
#(
   parameter int unsigned BYTES = ROM_BYTES,
   parameter int unsigned COUNT = ROM_COUNT
) (
   input  logic [15:0]      offset,
   output logic             valid,
   output logic [COUNT-1:0] sel,
   output logic [12:0]      addr
);

   localparam int unsigned AW = $clog2(BYTES);

   logic [15:0] idx;

   always_comb begin
      idx   = offset >> AW;
      valid = ({16'd0, offset} < BYTES * COUNT);
      sel   = '0;
      for (int unsigned i = 0; i < COUNT; i++) begin
         if (valid && idx == 16'(i)) sel[i] = 1'b1;
      end
      addr  = 13'({16'd0, offset} & (BYTES - 1));
   end

endmodule

// File: rtl/prog_rom_loader.sv
// Writes the program ROM images from the ioctl download stream and keeps the
// 6502 in reset until a complete, correctly sized image is resident.
module prog_rom_loader #(
   parameter int unsigned ROM_BYTES      = prog_rom_pkg::ROM_BYTES,
   parameter int unsigned ROM_COUNT      = prog_rom_pkg::ROM_COUNT,
   parameter int unsigned RELEASE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ioctl_download,
   input  logic                 ioctl_wr,
   input  logic [15:0]          ioctl_addr,
   input  logic [7:0]           ioctl_dout,
   output logic                 ioctl_wait,
   output logic [ROM_COUNT-1:0] rom_we,
   output logic [12:0]          rom_waddr,
   output logic [7:0]           rom_wdata,
   output logic                 cpu_hold,
   output logic                 load_done,
   output logic                 load_err
);

   import prog_rom_pkg::*;

   localparam logic [15:0] IMAGE_CNT = 16'(ROM_BYTES * ROM_COUNT);
   localparam logic [15:0] REL_LAST  = 16'(RELEASE_CYCLES - 1);

   loader_state_t          state;
   logic                   dl_q;
   logic                   dl_rise;
   logic [15:0]            byte_cnt;
   logic [15:0]            rel_cnt;
   logic [ROM_COUNT-1:0]   wr_sel;
   logic                   dec_valid;
   logic [ROM_COUNT-1:0]   dec_sel;
   logic [12:0]            dec_addr;

   rom_image_decode #(
      .BYTES (ROM_BYTES),
      .COUNT (ROM_COUNT)
   ) u_decode (
      .offset (ioctl_addr),
      .valid  (dec_valid),
      .sel    (dec_sel),
      .addr   (dec_addr)
   );

   assign dl_rise = ioctl_download & ~dl_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         dl_q       <= 1'b0;
         byte_cnt   <= '0;
         rel_cnt    <= '0;
         wr_sel     <= '0;
         ioctl_wait <= 1'b0;
         rom_we     <= '0;
         rom_waddr  <= '0;
         rom_wdata  <= '0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         dl_q   <= ioctl_download;
         rom_we <= '0;
         case (state)
            ST_IDLE: begin
               if (dl_rise) begin
                  state     <= ST_LOAD;
                  byte_cnt  <= '0;
                  load_err  <= 1'b0;
                  load_done <= 1'b0;
               end
            end
            // A strobe wins over a simultaneous download fall; the fall is seen next LOAD cycle.
            ST_LOAD: begin
               if (ioctl_wr) begin
                  rom_waddr  <= dec_addr;
                  rom_wdata  <= ioctl_dout;
                  wr_sel     <= dec_valid ? dec_sel : '0;
                  ioctl_wait <= 1'b1;
                  state      <= ST_WRITE;
               end else if (!ioctl_download) begin
                  if (byte_cnt == IMAGE_CNT && !load_err) begin
                     rel_cnt <= '0;
                     state   <= ST_RELEASE;
                  end else begin
                     load_err <= 1'b1;
                     state    <= ST_ERROR;
                  end
               end
            end
            ST_WRITE: begin
               rom_we <= wr_sel;
               if (wr_sel != '0 && byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
               if (ioctl_wr) load_err <= 1'b1;
               state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               ioctl_wait <= 1'b0;
               if (ioctl_wr) load_err <= 1'b1;
               state <= ST_LOAD;
            end
            ST_RELEASE: begin
               if (rel_cnt == REL_LAST) begin
                  cpu_hold  <= 1'b0;
                  load_done <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  rel_cnt <= rel_cnt + 16'd1;
               end
            end
            ST_DONE, ST_ERROR: begin
               if (dl_rise) begin
                  state     <= ST_LOAD;
                  cpu_hold  <= 1'b1;
                  load_done <= 1'b0;
                  load_err  <= 1'b0;
                  byte_cnt  <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_rom_loader.sv
// Bench for prog_rom_loader: a full-size instance pinned with literal vectors and a
// reduced-size instance (256-byte ROMs) checked every cycle against a transaction model.
module tb_prog_rom_loader;

   localparam int unsigned SB   = 256;
   localparam int unsigned SC   = 5;
   localparam int unsigned REL  = 16;
   localparam int unsigned SIMG = SB * SC;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [15:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;

   logic        s_wait, s_hold, s_done, s_err;
   logic [4:0]  s_we;
   logic [12:0] s_waddr;
   logic [7:0]  s_wdata;
   logic        b_wait, b_hold, b_done, b_err;
   logic [4:0]  b_we;
   logic [12:0] b_waddr;
   logic [7:0]  b_wdata;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   bit          chk_en  = 1'b0;

   always #5 clk = ~clk;

   prog_rom_loader #(.ROM_BYTES(SB), .ROM_COUNT(SC), .RELEASE_CYCLES(REL)) u_small (
      .clk(clk), .resetn(resetn), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(s_wait), .rom_we(s_we),
      .rom_waddr(s_waddr), .rom_wdata(s_wdata), .cpu_hold(s_hold), .load_done(s_done),
      .load_err(s_err));

   prog_rom_loader u_big (
      .clk(clk), .resetn(resetn), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(b_wait), .rom_we(b_we),
      .rom_waddr(b_waddr), .rom_wdata(b_wdata), .cpu_hold(b_hold), .load_done(b_done),
      .load_err(b_err));

   function automatic logic [7:0] pat(input logic [15:0] o);
      return o[7:0] ^ o[15:8];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model of the reduced instance, advanced on every rising edge.
   int unsigned cyc = 0;
   logic        m_dl_q = 1'b0;
   bit          m_active = 0, m_drop = 0, m_acc_valid = 0, m_ev_valid = 0, m_rel_pending = 0;
   int unsigned m_count = 0, m_next_ok = 0, m_acc_at = 0, m_ev_due = 0, m_rel_at = 0;
   logic [4:0]  m_ev_we = '0;
   logic [12:0] m_ev_addr = '0;
   logic [7:0]  m_ev_data = '0;
   logic        e_hold = 1'b1, e_done = 1'b0, e_err = 1'b0;

   always @(posedge clk or negedge resetn) begin
      int unsigned a;
      if (!resetn) begin
         m_dl_q = 1'b0; m_active = 0; m_drop = 0; m_acc_valid = 0; m_ev_valid = 0;
         m_rel_pending = 0; m_count = 0;
         e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0;
      end else begin
         cyc++;
         if (m_rel_pending && cyc == m_rel_at) begin
            e_hold = 1'b0; e_done = 1'b1; m_rel_pending = 0;
         end
         if (ioctl_download && !m_dl_q && !m_active && !m_rel_pending) begin
            m_active = 1; m_count = 0; m_drop = 0; m_next_ok = cyc + 1;
            e_hold = 1'b1; e_done = 1'b0; e_err = 1'b0;
         end else if (m_active) begin
            if (ioctl_wr) begin
               if (cyc >= m_next_ok) begin
                  a = 32'(ioctl_addr);
                  m_ev_valid  = (a < SIMG);
                  m_ev_due    = cyc + 1;
                  m_ev_we     = (a < SIMG) ? 5'(1 << (a / SB)) : 5'd0;
                  m_ev_addr   = 13'(a % SB);
                  m_ev_data   = ioctl_dout;
                  m_acc_valid = 1; m_acc_at = cyc; m_next_ok = cyc + 3;
                  if (a < SIMG && m_count < 65535) m_count++;
               end else begin
                  m_drop = 1; e_err = 1'b1;
               end
            end else if (!ioctl_download && cyc >= m_next_ok) begin
               m_active = 0;
               if (m_count == SIMG && !m_drop) begin
                  m_rel_pending = 1; m_rel_at = cyc + REL;
               end else begin
                  e_err = 1'b1;
               end
            end
         end
         m_dl_q = ioctl_download;
      end
   end

   always @(negedge clk) begin
      logic [4:0] exp_we;
      logic       exp_wait;
      if (chk_en) begin
         exp_we   = (m_ev_valid && cyc == m_ev_due) ? m_ev_we : 5'd0;
         exp_wait = m_acc_valid && (cyc == m_acc_at || cyc == m_acc_at + 1);
         chk("rom_we", 32'(s_we), 32'(exp_we));
         if (exp_we != 5'd0) begin
            chk("rom_waddr", 32'(s_waddr), 32'(m_ev_addr));
            chk("rom_wdata", 32'(s_wdata), 32'(m_ev_data));
         end
         chk("ioctl_wait", 32'(s_wait), 32'(exp_wait));
         chk("cpu_hold", 32'(s_hold), 32'(e_hold));
         chk("load_done", 32'(s_done), 32'(e_done));
         chk("load_err", 32'(s_err), 32'(e_err));
      end
   end

   // Image capture of the reduced instance, compared against the pattern after each load.
   int unsigned wcnt [SC];
   logic [7:0]  cap  [SIMG];

   always @(negedge clk) begin
      for (int r = 0; r < int'(SC); r++) begin
         if (s_we[r] && s_waddr < 13'(SB)) begin
            wcnt[r]++;
            cap[r * int'(SB) + int'(s_waddr)] = s_wdata;
         end
      end
   end

   task automatic clear_cap();
      for (int r = 0; r < int'(SC); r++) wcnt[r] = 0;
      for (int k = 0; k < int'(SIMG); k++) cap[k] = ~pat(16'(k));
   endtask

   task automatic check_image(input string tag);
      int unsigned bad = 0;
      for (int r = 0; r < int'(SC); r++) chk({tag, "_rom_writes"}, wcnt[r], SB);
      for (int k = 0; k < int'(SIMG); k++) if (cap[k] !== pat(16'(k))) bad++;
      chk({tag, "_image_contents"}, bad, 0);
   endtask

   task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      @(posedge clk); #1 ioctl_wr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic load_image(input int unsigned n, input int unsigned extra);
      ioctl_download = 1'b1;
      @(posedge clk); #1;
      for (int unsigned i = 0; i < n; i++) send_byte(16'(i), pat(16'(i)));
      for (int unsigned j = 0; j < extra; j++) send_byte(16'(32'hA000 + j), pat(16'(32'hA000 + j)));
   endtask

   // Drops ioctl_download and counts edges until the reduced instance releases the CPU.
   task automatic end_dl(output int unsigned n);
      n = 0;
      ioctl_download = 1'b0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (s_hold == 1'b0) break;
      end
   endtask

   logic [15:0] v_addr  [4] = '{16'h6005, 16'h9FFF, 16'hA000, 16'h0000};
   logic [7:0]  v_data  [4] = '{8'hA5, 8'h3C, 8'h77, 8'h11};
   logic [4:0]  v_we    [4] = '{5'b01000, 5'b10000, 5'b00000, 5'b00001};
   logic [12:0] v_waddr [4] = '{13'h0005, 13'h1FFF, 13'h0000, 13'h0000};

   initial begin
      int unsigned n;
      int unsigned total;
      #2 resetn = 1'b0;
      #1 chk_en = 1'b1;
      chk("rst_hold", 32'(s_hold), 1);
      chk("rst_wait", 32'(s_wait), 0);
      chk("rst_we", 32'(s_we), 0);
      chk("rst_waddr", 32'(s_waddr), 0);
      chk("rst_wdata", 32'(s_wdata), 0);
      chk("rst_done", 32'(s_done), 0);
      chk("rst_err", 32'(s_err), 0);
      chk("big_rst_hold", 32'(b_hold), 1);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;

      // Literal strobe timing and ROM mapping on the full-size instance.
      ioctl_download = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         ioctl_addr = v_addr[i]; ioctl_dout = v_data[i]; ioctl_wr = 1'b1;
         @(posedge clk); #1 ioctl_wr = 1'b0;
         chk("big_wait_n1", 32'(b_wait), 1);
         chk("big_we_n1", 32'(b_we), 0);
         @(posedge clk); #1;
         chk("big_we_n2", 32'(b_we), 32'(v_we[i]));
         chk("big_wait_n2", 32'(b_wait), 1);
         if (v_we[i] != 5'd0) begin
            chk("big_waddr_n2", 32'(b_waddr), 32'(v_waddr[i]));
            chk("big_wdata_n2", 32'(b_wdata), 32'(v_data[i]));
         end
         @(posedge clk); #1;
         chk("big_wait_n3", 32'(b_wait), 0);
         chk("big_we_n3", 32'(b_we), 0);
      end
      end_dl(n);
      chk("big_short_err", 32'(b_err), 1);
      chk("big_short_hold", 32'(b_hold), 1);
      chk("big_short_done", 32'(b_done), 0);

      // Full image on the reduced instance.
      clear_cap();
      load_image(SIMG, 0);
      end_dl(n);
      chk("full_release_latency", n, 17);
      chk("full_done", 32'(s_done), 1);
      chk("full_err", 32'(s_err), 0);
      check_image("full");
      chk("big_partial_err", 32'(b_err), 1);
      chk("big_partial_hold", 32'(b_hold), 1);

      // One byte short.
      load_image(SIMG - 1, 0);
      end_dl(n);
      chk("short_err", 32'(s_err), 1);
      chk("short_hold", 32'(s_hold), 1);
      chk("short_done", 32'(s_done), 0);

      // Full image followed by out-of-range bytes.
      clear_cap();
      load_image(SIMG, 100);
      end_dl(n);
      chk("extra_release_latency", n, 17);
      chk("extra_done", 32'(s_done), 1);
      total = 0;
      for (int r = 0; r < int'(SC); r++) total += wcnt[r];
      chk("extra_total_writes", total, SIMG);

      // Back-to-back strobe: second byte dropped, count still correct.
      ioctl_download = 1'b1;
      @(posedge clk); #1;
      ioctl_addr = 16'd0; ioctl_dout = pat(16'd0); ioctl_wr = 1'b1;
      @(posedge clk); #1;
      ioctl_addr = 16'd1; ioctl_dout = pat(16'd1);
      @(posedge clk); #1 ioctl_wr = 1'b0;
      chk("drop_err_now", 32'(s_err), 1);
      @(posedge clk); #1;
      for (int unsigned i = 1; i < SIMG; i++) send_byte(16'(i), pat(16'(i)));
      end_dl(n);
      chk("drop_err", 32'(s_err), 1);
      chk("drop_hold", 32'(s_hold), 1);
      chk("drop_done", 32'(s_done), 0);

      // Reset asserted while a byte sits between strobe and write.
      ioctl_download = 1'b1;
      @(posedge clk); #1;
      for (int unsigned i = 0; i < 600; i++) send_byte(16'(i), pat(16'(i)));
      ioctl_addr = 16'd600; ioctl_dout = pat(16'd600); ioctl_wr = 1'b1;
      @(posedge clk); #1 ioctl_wr = 1'b0;
      resetn = 1'b0;
      #1;
      chk("midrst_hold", 32'(s_hold), 1);
      chk("midrst_wait", 32'(s_wait), 0);
      chk("midrst_we", 32'(s_we), 0);
      chk("midrst_waddr", 32'(s_waddr), 0);
      chk("midrst_wdata", 32'(s_wdata), 0);
      chk("midrst_done", 32'(s_done), 0);
      chk("midrst_err", 32'(s_err), 0);
      chk("big_midrst_wait", 32'(b_wait), 0);
      @(posedge clk); #1;
      chk("midrst_no_write", 32'(s_we), 0);
      ioctl_download = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;
      clear_cap();
      load_image(SIMG, 0);
      end_dl(n);
      chk("after_rst_release_latency", n, 17);
      chk("after_rst_done", 32'(s_done), 1);
      chk("after_rst_err", 32'(s_err), 0);
      check_image("after_rst");

      repeat (4) @(posedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
